// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares a single memory port between the fetch stage and the MEM stage.
// Data accesses normally win; fetch gets a forced turn once data has won
// STARVE_MAX back-to-back grants while fetch was waiting. A grant that sees
// no mem_ack for TIMEOUT cycles is abandoned: the requester still gets its
// ack, with zero read data, and the sticky err flag is raised.
//
// state  | meaning
// IDLE   | no transaction; arbitrates between pending requests
// GNT_IF | fetch owns the memory port, mem_req high
// GNT_D  | data stage owns the memory port, mem_req high
// DONE   | winner's ack pulses for this cycle; no new grant
module mem_port_arbiter #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IF = 2'd1,
    GNT_D  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  // wait_cnt holds the number of ack-less grant cycles already elapsed, so
  // the cycle that would make it equal TIMEOUT is the one that gives up.
  localparam logic [7:0] WAIT_LAST  = 8'(TIMEOUT - 1);

  state_t     state;
  logic [3:0] starve_cnt;
  logic [7:0] wait_cnt;
  logic       grant_d;
  logic       wait_expired;

  // Pipeline freeze depends only on live requests and the current ack pulse.
  assign stall = (if_req & ~if_ack) | (d_req & ~d_ack);

  // Arbitration and timeout decisions for the current cycle.
  always_comb begin
    grant_d      = d_req & ~(if_req & (starve_cnt == STARVE_LIM));
    wait_expired = (wait_cnt == WAIT_LAST);
  end

  // Sequencer: grant, hold the port until ack or timeout, pulse ack, return.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      if_ack     <= 1'b0;
      d_ack      <= 1'b0;
      err        <= 1'b0;
      starve_cnt <= '0;
      wait_cnt   <= '0;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (d_req || if_req) begin
            mem_req  <= 1'b1;
            wait_cnt <= '0;
            if (grant_d) begin
              state     <= GNT_D;
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              if (!if_req) begin
                starve_cnt <= '0;
              end else if (starve_cnt != STARVE_LIM) begin
                starve_cnt <= starve_cnt + 4'd1;
              end
            end else begin
              // Fetch keeps the previous store data on mem_wdata.
              state      <= GNT_IF;
              mem_we     <= 1'b0;
              mem_addr   <= if_addr;
              starve_cnt <= '0;
            end
          end
        end

        GNT_IF, GNT_D: begin
          if (!mem_ack) begin
            wait_cnt <= wait_cnt + 8'd1;
          end
          // A real ack takes priority over a timeout landing on the same cycle.
          if (mem_ack || wait_expired) begin
            mem_req <= 1'b0;
            state   <= DONE;
            if (!mem_ack) begin
              err <= 1'b1;
            end
            if (state == GNT_IF) begin
              if_ack   <= 1'b1;
              if_rdata <= mem_ack ? mem_rdata : '0;
            end else begin
              d_ack <= 1'b1;
              if (!mem_ack) begin
                d_rdata <= '0;
              end else if (!mem_we) begin
                d_rdata <= mem_rdata;
              end
            end
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios plus a randomized run
// checked against a transaction-timeline model of the arbiter.
module tb_mem_port_arbiter;

  localparam int STARVE = 4;
  localparam int TMO    = 8;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        stall;
  logic        err;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(.STARVE_MAX(STARVE), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall(stall), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b0; if_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // timeline model state for the randomized run
  int          grant_cyc, mack_cyc, ack_cyc, free_cyc, win, starve, n;
  bit          ip, dp, dwe, e_we, exp_req, e_ia, e_da, inwin;
  logic [31:0] ia, da, dw, e_addr, e_wdata, e_if_rdata, e_d_rdata, rd;
  logic [31:0] marr [8];
  logic [2:0]  idx;

  initial begin
    rst = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
    #12;
    chk("rst_mem_req",   mem_req,   0);
    chk("rst_mem_we",    mem_we,    0);
    chk("rst_mem_addr",  mem_addr,  0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_if_rdata",  if_rdata,  0);
    chk("rst_d_rdata",   d_rdata,   0);
    chk("rst_acks",      {if_ack, d_ack}, 0);
    chk("rst_err",       err,       0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // fetch only, minimum latency
    if_req = 1'b1; if_addr = 32'h10;
    tick();
    chk("f_mem_req", mem_req, 1);
    chk("f_mem_addr", mem_addr, 32'h10);
    chk("f_mem_we", mem_we, 0);
    chk("f_if_ack_early", if_ack, 0);
    mem_ack = 1'b1; mem_rdata = 32'h8C220004;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    chk("f_if_ack", if_ack, 1);
    chk("f_if_rdata", if_rdata, 32'h8C220004);
    chk("f_mem_req_drop", mem_req, 0);
    chk("f_stall", stall, 0);
    if_req = 1'b0;
    tick();
    chk("f_ack_one_cycle", if_ack, 0);

    // simultaneous: data store wins, then fetch
    if_req = 1'b1; if_addr = 32'h44;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h55;
    tick();
    chk("s_mem_we", mem_we, 1);
    chk("s_mem_addr", mem_addr, 32'h20);
    chk("s_mem_wdata", mem_wdata, 32'h55);
    chk("s_stall", stall, 1);
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick();
    mem_ack = 1'b0;
    chk("s_d_ack", d_ack, 1);
    chk("s_if_ack_none", if_ack, 0);
    chk("s_d_rdata_kept", d_rdata, 0);
    d_req = 1'b0;
    tick();
    chk("s_idle_gap", mem_req, 0);
    tick();
    chk("s_if_addr", mem_addr, 32'h44);
    chk("s_if_we", mem_we, 0);
    chk("s_wdata_kept", mem_wdata, 32'h55);
    mem_ack = 1'b1; mem_rdata = 32'h12345678;
    tick();
    mem_ack = 1'b0;
    chk("s_if_ack", if_ack, 1);
    chk("s_if_rdata", if_rdata, 32'h12345678);
    if_req = 1'b0;
    tick();

    // stray mem_ack while idle
    mem_ack = 1'b1; mem_rdata = 32'hFFFF0000;
    tick();
    chk("y_mem_req", mem_req, 0);
    chk("y_acks", {if_ack, d_ack}, 0);
    tick();
    mem_ack = 1'b0;
    chk("y_if_rdata", if_rdata, 32'h12345678);
    chk("y_d_rdata", d_rdata, 0);
    chk("y_acks2", {if_ack, d_ack}, 0);
    tick();

    // starvation: D,D,D,D,IF,D
    if_req = 1'b1; if_addr = 32'h200; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("starve_gnt%0d", k), mem_addr, (k == 4) ? 32'h200 : 32'h100);
      mem_ack = 1'b1; mem_rdata = 32'(k);
      tick();
      mem_ack = 1'b0;
      tick();
    end
    if_req = 1'b0; d_req = 1'b0;
    tick();

    // randomized run against the timeline model
    reset_dut();
    for (int i = 0; i < 8; i++) marr[i] = $urandom;
    grant_cyc = -10; mack_cyc = -10; ack_cyc = -10; free_cyc = 0; win = 0; starve = 0;
    ip = 0; dp = 0; dwe = 0; ia = '0; da = '0; dw = '0;
    e_addr = '0; e_we = 0; e_wdata = '0; e_if_rdata = '0; e_d_rdata = '0;
    for (int c = 0; c < 600; c++) begin
      exp_req = (win != 0) && (c > grant_cyc) && (c <= mack_cyc);
      e_ia = (c == ack_cyc) && (win == 1);
      e_da = (c == ack_cyc) && (win == 2);
      chk("r_mem_req", mem_req, exp_req);
      chk("r_if_ack", if_ack, e_ia);
      chk("r_d_ack", d_ack, e_da);
      chk("r_if_rdata", if_rdata, e_if_rdata);
      chk("r_d_rdata", d_rdata, e_d_rdata);
      chk("r_err", err, 0);
      if (exp_req) begin
        chk("r_mem_addr", mem_addr, e_addr);
        chk("r_mem_we", mem_we, e_we);
        chk("r_mem_wdata", mem_wdata, e_wdata);
      end
      if (c == ack_cyc) begin
        if (win == 1) ip = 0; else dp = 0;
        win = 0;
      end
      // requester abandoning its request mid-grant
      if (win == 1 && c > grant_cyc && $urandom_range(0, 7) == 0) ip = 0;
      if (win == 2 && c > grant_cyc && $urandom_range(0, 7) == 0) dp = 0;
      if (!ip && win != 1 && $urandom_range(0, 1) == 1) begin
        ip = 1; ia = $urandom;
      end
      if (!dp && win != 2 && $urandom_range(0, 1) == 1) begin
        dp = 1; da = $urandom; dw = $urandom; dwe = 1'($urandom_range(0, 1));
      end
      if (win == 0 && c >= free_cyc && (ip || dp)) begin
        if (dp && !(ip && starve == STARVE)) begin
          win = 2; e_addr = da; e_we = dwe; e_wdata = dw;
          starve = ip ? ((starve < STARVE) ? starve + 1 : starve) : 0;
        end else begin
          win = 1; e_addr = ia; e_we = 0; starve = 0;
        end
        grant_cyc = c;
        mack_cyc  = c + 1 + int'($urandom_range(0, 3));
        ack_cyc   = mack_cyc + 1;
        free_cyc  = ack_cyc + 1;
      end
      inwin = (win != 0) && (c > grant_cyc) && (c <= mack_cyc);
      rd = $urandom;
      if (c == mack_cyc) begin
        idx = e_addr[4:2];
        if (win == 1) begin
          rd = marr[idx]; e_if_rdata = rd;
        end else if (!e_we) begin
          rd = marr[idx]; e_d_rdata = rd;
        end else begin
          marr[idx] = e_wdata;
        end
        mem_ack = 1'b1;
      end else begin
        mem_ack = (!inwin && $urandom_range(0, 5) == 0);
      end
      mem_rdata = rd;
      if_req = ip; if_addr = ia;
      d_req = dp; d_addr = da; d_wdata = dw; d_we = dwe;
      #1;
      chk("r_stall", stall, (ip & ~e_ia) | (dp & ~e_da));
      tick();
    end

    // reset in the middle of a grant
    reset_dut();
    if_req = 1'b1; if_addr = 32'h30;
    tick();
    chk("m_mem_req", mem_req, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("m_async_req", mem_req, 0);
    chk("m_async_addr", mem_addr, 0);
    @(posedge clk);
    #1;
    chk("m_no_ack", if_ack, 0);
    rst = 1'b1;
    tick();
    chk("m_regrant", mem_req, 1);
    chk("m_regrant_addr", mem_addr, 32'h30);
    mem_ack = 1'b1; mem_rdata = 32'h77;
    tick();
    mem_ack = 1'b0;
    chk("m_if_ack", if_ack, 1);
    chk("m_if_rdata", if_rdata, 32'h77);
    if_req = 1'b0;
    tick();

    // timeout on a data read
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    tick();
    mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    tick();
    mem_ack = 1'b0;
    chk("t_pre_rdata", d_rdata, 32'hCAFEF00D);
    d_req = 1'b0;
    tick();
    d_req = 1'b1; d_addr = 32'h48;
    tick();
    chk("t_wait_stall", stall, 1);
    n = 0;
    while (mem_req === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    chk("t_len", n, TMO);
    chk("t_mem_req", mem_req, 0);
    chk("t_d_ack", d_ack, 1);
    chk("t_d_rdata", d_rdata, 0);
    chk("t_err", err, 1);
    d_req = 1'b0;
    tick();
    tick();
    chk("t_err_sticky", err, 1);
    chk("t_d_ack_once", d_ack, 0);
    rst = 1'b0;
    #1;
    chk("t_err_rst", err, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
